// File: rtl/maple_rx_ctrl_if.sv
// Maple receive-controller bus: byte stream from maple_in plus decoded header,
// per-byte forwarding and packet status toward downstream logic.
interface maple_rx_ctrl_if;
  logic        data_produce;
  logic [7:0]  data;
  logic        end_detected;
  logic        trigger_start;
  logic        byte_strobe;
  logic [10:0] byte_index;
  logic [7:0]  hdr_len;
  logic [7:0]  hdr_sender;
  logic [7:0]  hdr_recipient;
  logic [7:0]  hdr_cmd;
  logic        pkt_done;
  logic        pkt_ok;
  logic        len_err;
  logic        crc_err;
  logic        timeout_err;
  logic [15:0] pkt_count;

  modport master (
    output data_produce, data, end_detected,
    input  trigger_start, byte_strobe, byte_index,
    input  hdr_len, hdr_sender, hdr_recipient, hdr_cmd,
    input  pkt_done, pkt_ok, len_err, crc_err, timeout_err, pkt_count
  );

  modport slave (
    input  data_produce, data, end_detected,
    output trigger_start, byte_strobe, byte_index,
    output hdr_len, hdr_sender, hdr_recipient, hdr_cmd,
    output pkt_done, pkt_ok, len_err, crc_err, timeout_err, pkt_count
  );
endinterface

// File: rtl/maple_rx_ctrl.sv
// Maple bus receive controller: arms maple_in, counts and forwards bytes, latches the
// header and reports packet status. Define MAPLE_RX_CRC_EN to enable the XOR checksum check.
module maple_rx_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input logic            clk,
  input logic            rst,
  maple_rx_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ARM, LISTEN, RECV, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        armed;
  logic [10:0] byte_cnt;
  logic [10:0] cnt_nxt;
  logic [15:0] tmo_cnt;
  logic [7:0]  hdr_len_q;
  logic [7:0]  hdr_sender_q;
  logic [7:0]  hdr_recipient_q;
  logic [7:0]  hdr_cmd_q;
  logic [7:0]  len_eff;
  logic [10:0] len_expect;
  logic        len_mismatch;
  logic        byte_take;
  logic        finish_end;
  logic        finish_tmo;
  logic        crc_bad;
  logic        len_err_q;
  logic        crc_err_q;
  logic        timeout_err_q;
  logic        pkt_ok_q;
  logic [15:0] pkt_count_q;
  logic        strobe_q;
  logic [10:0] index_q;

  // A coincident byte and end pulse are evaluated together: the byte is counted
  // (and may itself be header byte 0) before the length check is made.
  always_comb begin
    byte_take    = bus.data_produce && ((state == LISTEN) || (state == RECV));
    cnt_nxt      = byte_cnt;
    if (byte_take && (byte_cnt != 11'd2047)) begin
      cnt_nxt = byte_cnt + 11'd1;
    end
    len_eff      = (byte_take && (byte_cnt == 11'd0)) ? bus.data : hdr_len_q;
    len_expect   = {1'b0, len_eff, 2'b00} + 11'd5;
    len_mismatch = (cnt_nxt != len_expect);
    finish_end   = bus.end_detected && ((state == RECV) || ((state == LISTEN) && byte_take));
    finish_tmo   = (state == RECV) && !bus.data_produce && !bus.end_detected &&
                   (tmo_cnt >= (TIMEOUT - 16'd1));
  end

`ifdef MAPLE_RX_CRC_EN
  logic [7:0] xor_q;
  logic [7:0] xor_nxt;

  always_comb begin
    xor_nxt = byte_take ? (xor_q ^ bus.data) : xor_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= 8'h00;
    end else if (state == ARM) begin
      xor_q <= 8'h00;
    end else begin
      xor_q <= xor_nxt;
    end
  end

  assign crc_bad = |xor_nxt;
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARM;
    end else begin
      state <= state_nxt;
    end
  end

  // ARM waits one edge after reset so trigger_start never overlaps reset release.
  always_comb begin
    state_nxt = state;
    case (state)
      ARM: begin
        if (armed) begin
          state_nxt = LISTEN;
        end
      end
      LISTEN: begin
        if (finish_end) begin
          state_nxt = DONE;
        end else if (byte_take) begin
          state_nxt = RECV;
        end else if (bus.end_detected) begin
          state_nxt = ARM;
        end
      end
      RECV: begin
        if (finish_end || finish_tmo) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = ARM;
      end
      default: begin
        state_nxt = ARM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      byte_cnt <= 11'd0;
      tmo_cnt  <= 16'd0;
      strobe_q <= 1'b0;
      index_q  <= 11'd0;
    end else begin
      armed    <= 1'b1;
      strobe_q <= bus.data_produce;
      if (bus.data_produce) begin
        index_q <= byte_cnt;
      end
      // The timeout counter holds the number of cycles since the last byte.
      if (state == ARM) begin
        byte_cnt <= 11'd0;
        tmo_cnt  <= 16'd0;
      end else if (byte_take) begin
        byte_cnt <= cnt_nxt;
        tmo_cnt  <= 16'd1;
      end else if (state == RECV) begin
        tmo_cnt  <= tmo_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_len_q       <= 8'h00;
      hdr_sender_q    <= 8'h00;
      hdr_recipient_q <= 8'h00;
      hdr_cmd_q       <= 8'h00;
    end else if (byte_take && (byte_cnt < 11'd4)) begin
      case (byte_cnt[1:0])
        2'd0: hdr_len_q       <= bus.data;
        2'd1: hdr_sender_q    <= bus.data;
        2'd2: hdr_recipient_q <= bus.data;
        2'd3: hdr_cmd_q       <= bus.data;
      endcase
    end
  end

  // Status is registered on entry to DONE so it is valid during the pkt_done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      pkt_ok_q      <= 1'b0;
      pkt_count_q   <= 16'd0;
    end else if (finish_end) begin
      len_err_q     <= len_mismatch;
      crc_err_q     <= crc_bad;
      timeout_err_q <= 1'b0;
      pkt_ok_q      <= !(len_mismatch || crc_bad);
      pkt_count_q   <= pkt_count_q + 16'd1;
    end else if (finish_tmo) begin
      len_err_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b1;
      pkt_ok_q      <= 1'b0;
      pkt_count_q   <= pkt_count_q + 16'd1;
    end
  end

  assign bus.trigger_start = (state == ARM) && armed;
  assign bus.pkt_done      = (state == DONE);
  assign bus.byte_strobe   = strobe_q;
  assign bus.byte_index    = index_q;
  assign bus.hdr_len       = hdr_len_q;
  assign bus.hdr_sender    = hdr_sender_q;
  assign bus.hdr_recipient = hdr_recipient_q;
  assign bus.hdr_cmd       = hdr_cmd_q;
  assign bus.pkt_ok        = pkt_ok_q;
  assign bus.len_err       = len_err_q;
  assign bus.crc_err       = crc_err_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_maple_rx_ctrl.sv
// Self-checking bench for maple_rx_ctrl: directed vector table, multi-cycle corner
// sequences and randomized packets scored against a packet-level model.
module tb_maple_rx_ctrl;

  localparam logic [15:0] TMO = 16'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  maple_rx_ctrl_if bus ();

  maple_rx_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] len;
    int         n;
    bit         corrupt;
    int         mode;        // 0 end after last byte, 1 end coincident, 2 timeout
    bit         exp_len;
    bit         exp_crcbad;
    bit         exp_tmo;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  pkt_q[$];
  logic [7:0]  exp_hdr[4];
  int          exp_count = 0;
  logic        prev_dp = 1'b0;
  logic [10:0] prev_idx = '0;
  logic        last_done, last_trig;
  logic        cap_ok, cap_len, cap_crc, cap_tmo;
  logic [7:0]  cap_hdr[4];
  logic [15:0] cap_count;
  vec_t        vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: sample the outputs of the current cycle at negedge, then drive its inputs.
  task automatic applyStimulus(input logic dp, input logic [7:0] d, input logic ed, input logic [10:0] idx);
    @(negedge clk);
    last_done = bus.pkt_done;
    last_trig = bus.trigger_start;
    if (bus.pkt_done) begin
      cap_ok    = bus.pkt_ok;
      cap_len   = bus.len_err;
      cap_crc   = bus.crc_err;
      cap_tmo   = bus.timeout_err;
      cap_hdr   = '{bus.hdr_len, bus.hdr_sender, bus.hdr_recipient, bus.hdr_cmd};
      cap_count = bus.pkt_count;
    end
    if (!rst) begin
      checkOutput("byte_strobe", bus.byte_strobe, prev_dp);
      if (prev_dp) checkOutput("byte_index", bus.byte_index, prev_idx);
    end
    bus.data_produce = dp;
    bus.data         = d;
    bus.end_detected = ed;
    prev_dp          = dp;
    prev_idx         = idx;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 11'd0);
  endtask

  task automatic build_pkt(input logic [7:0] len, input int n, input bit corrupt, input bit rnd);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    pkt_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0)        b = len;
      else if (rnd)      b = 8'($urandom);
      else if (i == 1)   b = 8'h20;
      else if (i == 2)   b = 8'h00;
      else if (i == 3)   b = 8'h08;
      else               b = 8'(i * 17 + 1);
      if (i == n - 1 && n > 1) b = x ^ (corrupt ? 8'h5A : 8'h00);
      x ^= b;
      pkt_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input string tag, input int mode, input bit exp_len, input bit exp_crcbad,
                          input bit exp_tmo, input int max_gap);
    int  got;
    int  delay_exp;
    bit  exp_crc;
    bit  exp_ok;
    for (int i = 0; i < pkt_q.size(); i++) begin
      bit last;
      last = (i == pkt_q.size() - 1);
      applyStimulus(1'b1, pkt_q[i], (mode == 1) && last, 11'(i));
      if (i < 4) exp_hdr[i] = pkt_q[i];
      if (!last) repeat ($urandom_range(0, max_gap)) idle();
    end
    if (mode == 0) applyStimulus(1'b0, 8'h00, 1'b1, 11'd0);
`ifdef MAPLE_RX_CRC_EN
    exp_crc = exp_crcbad && (mode != 2);
`else
    exp_crc = 1'b0;
`endif
    exp_ok    = !(exp_len || exp_crc || exp_tmo);
    delay_exp = (mode == 2) ? int'(TMO) : 1;
    got = 0;
    for (int k = 1; k <= delay_exp + 4 && got == 0; k++) begin
      idle();
      if (last_done) got = k;
    end
    checkOutput({tag, ":done_delay"}, got, delay_exp);
    if (got != 0) begin
      exp_count++;
      checkOutput({tag, ":len_err"}, cap_len, exp_len);
      checkOutput({tag, ":crc_err"}, cap_crc, exp_crc);
      checkOutput({tag, ":timeout_err"}, cap_tmo, exp_tmo);
      checkOutput({tag, ":pkt_ok"}, cap_ok, exp_ok);
      checkOutput({tag, ":pkt_count"}, cap_count, exp_count);
      for (int h = 0; h < 4; h++) checkOutput({tag, ":hdr"}, cap_hdr[h], exp_hdr[h]);
    end
    idle();
    checkOutput({tag, ":trigger_after_done"}, last_trig, 1'b1);
    checkOutput({tag, ":done_single_pulse"}, last_done, 1'b0);
    checkOutput({tag, ":pkt_ok_held"}, bus.pkt_ok, exp_ok);
  endtask

  initial begin
    bus.data_produce = 1'b0;
    bus.data         = 8'h00;
    bus.end_detected = 1'b0;
    for (int h = 0; h < 4; h++) exp_hdr[h] = 8'h00;

    vecs[0] = '{8'h03, 17, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 17, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 10, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h03, 17, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h03,  6, 1'b1, 2, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h00,  5, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00,  4, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h01,  9, 1'b0, 1, 1'b0, 1'b0, 1'b0};

    // Reset state and release timing.
    repeat (3) idle();
    checkOutput("rst:trigger_start", bus.trigger_start, 1'b0);
    checkOutput("rst:byte_strobe", bus.byte_strobe, 1'b0);
    checkOutput("rst:pkt_done", bus.pkt_done, 1'b0);
    checkOutput("rst:pkt_ok", bus.pkt_ok, 1'b0);
    checkOutput("rst:pkt_count", bus.pkt_count, 16'd0);
    checkOutput("rst:hdr_cmd", bus.hdr_cmd, 8'h00);
    checkOutput("rst:flags", {bus.len_err, bus.crc_err, bus.timeout_err}, 3'b000);
    rst = 1'b0;
    #1;
    checkOutput("release:trigger_before_edge", bus.trigger_start, 1'b0);
    idle();
    checkOutput("release:trigger_first_edge", last_trig, 1'b1);
    idle();
    checkOutput("release:trigger_one_cycle", last_trig, 1'b0);

    // End pulse while listening with no byte: re-arm without pkt_done.
    applyStimulus(1'b0, 8'h00, 1'b1, 11'd0);
    idle();
    checkOutput("listen_end:no_done", last_done, 1'b0);
    checkOutput("listen_end:rearm", last_trig, 1'b1);
    idle();
    checkOutput("listen_end:trigger_one_cycle", last_trig, 1'b0);

    // Reset in the middle of a packet discards it.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 11'(i));
    idle();
    rst = 1'b1;
    #1;
    checkOutput("midrst:pkt_done", bus.pkt_done, 1'b0);
    checkOutput("midrst:hdr_len_cleared", bus.hdr_len, 8'h00);
    idle();
    rst = 1'b0;
    for (int h = 0; h < 4; h++) exp_hdr[h] = 8'h00;
    idle();
    checkOutput("midrst:rearm", last_trig, 1'b1);
    checkOutput("midrst:no_done", last_done, 1'b0);
    repeat (TMO + 2) begin
      idle();
      checkOutput("midrst:no_late_done", last_done, 1'b0);
    end
    checkOutput("midrst:pkt_count", bus.pkt_count, exp_count);

    // Directed vector table.
    foreach (vecs[v]) begin
      build_pkt(vecs[v].len, vecs[v].n, vecs[v].corrupt, 1'b0);
      send_pkt($sformatf("vec%0d", v), vecs[v].mode, vecs[v].exp_len, vecs[v].exp_crcbad,
               vecs[v].exp_tmo, 0);
    end

    // Randomized packets against the packet-level model.
    for (int p = 0; p < 40; p++) begin
      logic [7:0] len;
      int         mode;
      int         n;
      logic [7:0] x;
      bit         e_len;
      len  = 8'($urandom_range(0, 5));
      mode = $urandom_range(0, 2);
      n    = ($urandom_range(0, 1) == 1) ? 4 * int'(len) + 5 : $urandom_range(2, 30);
      build_pkt(len, n, $urandom_range(0, 3) == 0, 1'b1);
      x = 8'h00;
      foreach (pkt_q[i]) x ^= pkt_q[i];
      e_len = (mode != 2) && (n != 4 * int'(len) + 5);
      repeat ($urandom_range(0, 2)) idle();
      send_pkt($sformatf("rnd%0d", p), mode, e_len, x != 8'h00, mode == 2, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maple_rx_ctrl.md
MAPLE_RX_CTRL -- requirements
Module: maple_rx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd4000, meaning clk cycles allowed between received bytes in RECV before abort.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_produce  input  1  one-cycle strobe from maple_in: byte valid on data.
REQ-005 SHALL have port data  input  8  received byte, valid only with data_produce.
REQ-006 SHALL have port end_detected  input  1  one-cycle end-of-packet pulse from maple_in.
REQ-007 SHALL have port trigger_start  output  1  one-cycle pulse that arms maple_in.
REQ-008 SHALL have ports byte_strobe  output  1  and byte_index  output  11  for per-byte forwarding to downstream decoders.
REQ-009 SHALL have ports hdr_len, hdr_sender, hdr_recipient, hdr_cmd  output  8 each  captured header bytes 0..3.
REQ-010 SHALL have ports pkt_done  output  1, pkt_ok  output  1, len_err  output  1, crc_err  output  1, timeout_err  output  1, and pkt_count  output  16 for packet-complete status.

Function
REQ-011 SHALL implement states ARM, LISTEN, RECV and DONE.
REQ-012 ARM: assert trigger_start for exactly one cycle, clear byte counter and running XOR, then go to LISTEN.
REQ-013 LISTEN: first data_produce -> RECV with that byte counted; end_detected with no byte received -> ARM, no pkt_done.
REQ-014 RECV: each data_produce increments an 11-bit byte counter (saturating at 2047), XORs data into the running checksum and reloads the timeout counter.
REQ-015 byte_strobe SHALL equal data_produce registered one cycle; byte_index SHALL be the zero-based index of that byte.
REQ-016 Bytes 0..3 SHALL be latched into hdr_len, hdr_sender, hdr_recipient, hdr_cmd; the hdr registers hold until the next packet's byte 0.
REQ-017 If data_produce and end_detected occur in the same cycle, the byte SHALL be counted first and then included in end evaluation.
REQ-018 On end_detected in RECV -> DONE; len_err = (byte_cnt != 4*hdr_len + 5), computed with 11-bit arithmetic.
REQ-019 Timeout counter reaching TIMEOUT in RECV without data_produce -> DONE with timeout_err=1 and len_err=0.
REQ-020 DONE: pkt_done pulses one cycle; pkt_ok = !(len_err|crc_err|timeout_err); pkt_count increments (wraps 65535->0); next state ARM.
REQ-021 Status flags SHALL be valid in the pkt_done cycle and held until the next pkt_done.
REQ-022 Round-trip latency: end_detected at cycle N -> pkt_done at N+1 -> trigger_start at N+2.

Reset
REQ-023 rst SHALL force state ARM and clear all counters, all hdr registers and all flags.
REQ-024 During reset, trigger_start, byte_strobe, pkt_done and pkt_ok SHALL be 0.
REQ-025 First trigger_start SHALL occur on the first clock edge after rst deasserts.
REQ-026 rst mid-packet SHALL discard the packet with no pkt_done and no pkt_count change.

Configuration
REQ-027 With MAPLE_RX_CRC_EN defined, DONE via end_detected SHALL set crc_err when the running XOR of all received bytes, including the final checksum byte, is nonzero.
REQ-028 Without MAPLE_RX_CRC_EN, crc_err SHALL be constant 0 and no XOR logic is required.
REQ-029 Timeout aborts SHALL leave crc_err=0 in both configurations.

Verification
REQ-030 Release rst -> trigger_start high exactly one cycle after the first edge; state LISTEN.
REQ-031 Packet 03,20,00,08, 12 payload bytes, correct XOR byte (17 bytes), then end_detected -> pkt_done with pkt_ok=1, hdr_cmd=08, pkt_count=1.
REQ-032 Same packet with last byte corrupted -> with MAPLE_RX_CRC_EN: crc_err=1, pkt_ok=0; without it: pkt_ok=1.
REQ-033 hdr_len=03 but only 10 bytes before end_detected -> len_err=1, pkt_ok=0; data_produce and end_detected coincident on the 17th byte -> len_err=0.
REQ-034 TIMEOUT=8, stop bytes after byte 5 -> pkt_done 8 cycles after the last byte with timeout_err=1, then trigger_start; pulse rst mid-packet -> no pkt_done, pkt_count unchanged.
